// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter that pops words from a show-ahead FIFO and
// sends start, LSB-first data, optional parity and 1-2 stop bits per frame.
module fifo_uart_tx #(
    parameter int DataWidth = 8,
    parameter int ClkDiv    = 16,
    parameter int ParityEn  = 0,
    parameter int ParityOdd = 0,
    parameter int StopBits  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DataWidth-1:0] fifo_data,
    output logic                 fifo_read_en,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(ClkDiv);
    localparam int BW = $clog2(DataWidth);
    localparam logic [CW-1:0] BaudLast = CW'(ClkDiv - 1);
    localparam logic [BW-1:0] DataLast = BW'(DataWidth - 1);
    localparam logic [BW-1:0] StopLast = BW'(StopBits - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e               state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DataWidth-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 bit_end;
    logic                 frame_end;

    assign bit_end   = baud_q == BaudLast;
    assign frame_end = state_q == STOP && bit_end && bit_q == StopLast;
    // Loading on the last stop cycle chains frames with no idle gap.
    assign fifo_read_en = reset_n && enable && !fifo_empty && (state_q == IDLE || frame_end);
    assign tx   = tx_q;
    assign busy = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            baud_q <= (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
            if (fifo_read_en) begin
                state_q  <= START;
                bit_q    <= '0;
                shift_q  <= fifo_data;
                parity_q <= ^fifo_data ^ (ParityOdd != 0);
                tx_q     <= 1'b0;
                busy_q   <= 1'b1;
            end else if (bit_end) begin
                case (state_q)
                    START: begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    DATA: begin
                        if (bit_q == DataLast) begin
                            state_q <= (ParityEn != 0) ? PARITY : STOP;
                            bit_q   <= '0;
                            tx_q    <= (ParityEn != 0) ? parity_q : 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    PARITY: begin
                        state_q <= STOP;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                    STOP: begin
                        if (bit_q == StopLast) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Single-clock UART transmitter that drains a show-ahead FIFO read port (the read side of `fifo_async`) and serialises each word onto an asynchronous serial line. It sits directly downstream of the FIFO in the read clock domain: it watches `fifo_empty`, samples `fifo_data`, and pops with a one-cycle `fifo_read_en` pulse. Frame format: start bit, `DataWidth` data bits LSB first, optional parity bit, then 1 or 2 stop bits.

## Interface
- `DataWidth`, 8: data word size in bits, 5..16.
- `ClkDiv`, 16: clock cycles per serial bit, ≥ 2.
- `ParityEn`, 0: 1 inserts a parity bit after the data bits.
- `ParityOdd`, 0: 0 selects even parity, 1 selects odd; ignored when `ParityEn`=0.
- `StopBits`, 1: number of stop bits, 1 or 2.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits popping new words; an in-flight frame always completes.
- `fifo_empty`  in  1  high when `fifo_data` is invalid.
- `fifo_data`  in  `DataWidth`  FIFO head word, valid when `fifo_empty`=0.
- `fifo_read_en`  out  1  one-cycle pop strobe.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while a frame is on the line, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Baud counter counts 0..`ClkDiv`-1 (width `$clog2(ClkDiv)`). Bit counter spans data bits (0..`DataWidth`-1) or stop bits (0..`StopBits`-1).
- Load condition: `enable` && !`fifo_empty` && (state==IDLE || last cycle of the last STOP bit).
- `fifo_read_en` = load condition. It is combinational from registered state and inputs, and forced 0 while `reset_n`=0.
- On the load edge:
  - `fifo_data` is latched into the shift register.
  - Parity is computed: XOR of the data bits, inverted if `ParityOdd`.
  - State becomes START, baud counter clears, `tx`<=0, `busy`<=1.
- Each state holds for `ClkDiv` cycles per bit.
- START → DATA: `tx` = shift[0]; shift right after each bit.
- DATA → PARITY after bit `DataWidth`-1 if `ParityEn`, else → STOP.
- PARITY → STOP; `tx` = parity bit.
- STOP: `tx`=1 for `StopBits`×`ClkDiv` cycles. At its last cycle:
  - load condition true → START directly, with no idle cycle (back-to-back).
  - otherwise → IDLE, `busy`<=0.
- Deasserting `enable` mid-frame has no effect on the current frame; it only blocks the next pop.
- `fifo_empty` and `fifo_data` are ignored outside the load-condition cycles.
- Reset (async): state IDLE, `tx`=1, `busy`=0, counters 0, shift register 0. A frame in progress is abandoned; its word is lost because it was already popped.

## Timing
- Pop-to-line latency: `tx` falls on the same edge that completes the `fifo_read_en` cycle, so the start bit begins the cycle after the pop.
- Frame length: (1 + `DataWidth` + `ParityEn` + `StopBits`) × `ClkDiv` cycles exactly.
- Back-to-back frames: consecutive pops are exactly one frame length apart; `busy` stays high continuously.
- At most one `fifo_read_en` pulse per frame. `fifo_read_en` is never high in two consecutive cycles.
- `busy` rises with the start bit and falls the cycle after the final stop-bit cycle when no word is loaded.
- Reset values: `tx`=1, `busy`=0, `fifo_read_en`=0.

## Test plan
- Reset: hold `reset_n`=0 with `fifo_empty`=0 and `enable`=1 → `tx`=1, `busy`=0, `fifo_read_en`=0 throughout. Assert `reset_n`=0 mid-DATA → `tx`=1 and `busy`=0 immediately (asynchronous).
- Single word: `ClkDiv`=4, no parity, 1 stop, data 0xA5 → one pop; `tx` = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each, 40 cycles total; `busy` high for exactly 40 cycles.
- Back-to-back: FIFO holds 0x01, 0x02, 0x03 → three pops exactly 40 cycles apart; no idle-high gap beyond the stop bit; `busy` continuously high for 120 cycles, then IDLE.
- Parity and stop bits:
  - `ParityEn`=1, `ParityOdd`=0, data 0x07 → parity bit 1.
  - `ParityOdd`=1, data 0x03 → parity bit 1.
  - `StopBits`=2 → stop high for 2×`ClkDiv` cycles; frame length 48 cycles at `ClkDiv`=4.
- Enable gating: drop `enable` during frame 1 of a 2-word FIFO → frame 1 completes, no second pop, `busy` falls. Re-raise `enable` → pop next cycle, frame 2 sent intact.
- Empty boundary: `fifo_empty` rises during the last STOP cycle → no pop, return to IDLE. `fifo_empty` falls later → pop in that cycle and start bit on the next cycle.
